cla_adder_128: RTL and testbench

- Registered carry-lookahead adder: a + b + c over WIDTH bits (default 128).
- Outputs: sum, carry-out, and the group propagate/generate pair for the full word.
- Sits in the datapath as a wide adder primitive. P_ik/G_ik allow it to be cascaded into a higher-level lookahead tree.
- Single clock domain. Outputs are registered, with one cycle of latency.

---
 rtl/cla_pkg.sv | 39 +++
 rtl/cla_node4.sv | 42 ++++
 rtl/cla_adder_128.sv | 136 +++++++++++++
 tb/tb_cla_adder_128.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and constants for the 4-ary carry-lookahead adder.
// Optional build macro used by the top level: CLA_IN_REG_EN.
package cla_pkg;

  localparam int CLA_WIDTH = 128;
  localparam int CLA_BLK   = 4;

  // Number of radix-sized tree levels needed to cover n leaves, rounded up.
  function automatic int cla_levels(input int n, input int radix);
    int lvl;
    int span;
    lvl  = 0;
    span = 1;
    while (span < n) begin
      span = span * radix;
      lvl  = lvl + 1;
    end
    return lvl;
  endfunction

  // Offset of tree level k inside a flat array holding every level,
  // leaves (level 0) first, root (level `levels`) last.
  function automatic int cla_off(input int radix, input int levels, input int k);
    int off;
    off = 0;
    for (int j = 0; j < k; j++) begin
      off = off + radix ** (levels - j);
    end
    return off;
  endfunction

  localparam int CLA_LEVELS = cla_levels(CLA_WIDTH, CLA_BLK);

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

endpackage

// File: rtl/cla_node4.sv
// One 4-input lookahead node: merges four (P,G) pairs into a group pair and
// derives the carries into children 1..3 from the node carry-in. Child 0
// simply inherits the node carry-in, which the parent wires up directly.
module cla_node4
  import cla_pkg::*;
(
  input  pg_t  [3:0] i_pg,
  input  logic       i_cy,
  output pg_t        o_pg,
  output logic [2:0] o_cy
);

  logic [3:0] w_p;
  logic [3:0] w_g;

  // Split the packed pairs into separate propagate/generate vectors.
  always_comb begin
    w_p = '0;
    w_g = '0;
    for (int k = 0; k < 4; k++) begin
      w_p[k] = i_pg[k].p;
      w_g[k] = i_pg[k].g;
    end
  end

  assign o_cy[0] = w_g[0]
                 | (w_p[0] & i_cy);
  assign o_cy[1] = w_g[1]
                 | (w_p[1] & w_g[0])
                 | (w_p[1] & w_p[0] & i_cy);
  assign o_cy[2] = w_g[2]
                 | (w_p[2] & w_g[1])
                 | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & i_cy);

  assign o_pg.p = &w_p;
  assign o_pg.g = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule

// File: rtl/cla_adder_128.sv
// Registered carry-lookahead adder: {carry_out,sum} = a + b + c, plus the
// whole-word group propagate/generate for cascading into a larger tree.
// Build option: define CLA_IN_REG_EN to register a/b/c before the tree
// (latency 2 instead of 1, still one result per cycle).
//
// The tree is built over BLK**LEVELS leaves. When WIDTH is not an exact
// power of BLK the surplus leaves are tied to p=1,g=0: that is the identity
// for the group equations, so the root P/G and all real carries are exact.
module cla_adder_128
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int BLK   = CLA_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             P_ik,
  output logic             G_ik
);

  localparam int LEVELS = cla_levels(WIDTH, BLK);
  localparam int NLEAF  = BLK ** LEVELS;
  localparam int TOTAL  = cla_off(BLK, LEVELS, LEVELS + 1);
  localparam int ROOT   = TOTAL - 1;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_c;

`ifdef CLA_IN_REG_EN
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;

  // Operand capture stage in front of the lookahead tree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= 1'b0;
    end else begin
      r_a <= a;
      r_b <= b;
      r_c <= c;
    end
  end

  assign w_a = r_a;
  assign w_b = r_b;
  assign w_c = r_c;
`else
  assign w_a = a;
  assign w_b = b;
  assign w_c = c;
`endif

  // Flat storage for every tree level: w_pg holds each entry's (P,G),
  // w_cy holds the carry flowing into that entry from above.
  pg_t  w_pg [TOTAL];
  logic w_cy [TOTAL];

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  genvar gi, gk, gj;

  // Bit-level propagate/generate, with identity padding above WIDTH.
  for (gi = 0; gi < NLEAF; gi++) begin : g_leaf
    if (gi < WIDTH) begin : g_real
      assign w_pg[gi] = '{p: w_a[gi] ^ w_b[gi], g: w_a[gi] & w_b[gi]};
    end else begin : g_pad
      assign w_pg[gi] = '{p: 1'b1, g: 1'b0};
    end
  end

  // Lookahead tree: level gk feeds nodes at level gk+1.
  for (gk = 0; gk < LEVELS; gk++) begin : g_level
    localparam int CO = cla_off(BLK, LEVELS, gk);
    localparam int PO = cla_off(BLK, LEVELS, gk + 1);
    for (gj = 0; gj < BLK ** (LEVELS - gk - 1); gj++) begin : g_node
      logic [2:0] w_node_cy;

      cla_node4 u_node (
        .i_pg ({w_pg[CO + BLK*gj + 3], w_pg[CO + BLK*gj + 2],
                w_pg[CO + BLK*gj + 1], w_pg[CO + BLK*gj]}),
        .i_cy (w_cy[PO + gj]),
        .o_pg (w_pg[PO + gj]),
        .o_cy (w_node_cy)
      );

      assign w_cy[CO + BLK*gj]     = w_cy[PO + gj];
      assign w_cy[CO + BLK*gj + 1] = w_node_cy[0];
      assign w_cy[CO + BLK*gj + 2] = w_node_cy[1];
      assign w_cy[CO + BLK*gj + 3] = w_node_cy[2];
    end
  end

  assign w_cy[ROOT] = w_c;
  assign w_cout     = w_pg[ROOT].g | (w_pg[ROOT].p & w_c);

  // Sum bits from bit propagate and the carry delivered by the tree.
  for (gi = 0; gi < WIDTH; gi++) begin : g_sum
    assign w_sum[gi] = w_pg[gi].p ^ w_cy[gi];
  end

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_p;
  logic             r_g;

  // Output stage: all four results update together on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_p    <= 1'b0;
      r_g    <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_cout;
      r_p    <= w_pg[ROOT].p;
      r_g    <= w_pg[ROOT].g;
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign P_ik      = r_p;
  assign G_ik      = r_g;

endmodule

// File: tb/tb_cla_adder_128.sv
// Self-checking bench for cla_adder_128 (honours CLA_IN_REG_EN for latency).
module tb_cla_adder_128;

  localparam int W = 128;
`ifdef CLA_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         P_ik;
  logic         G_ik;

  int checks   = 0;
  int failures = 0;

  cla_adder_128 #(.WIDTH(W), .BLK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .sum       (sum),
    .carry_out (carry_out),
    .P_ik      (P_ik),
    .G_ik      (G_ik)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact (W+1)-bit sum; G is carry of a+b alone; P is all-propagate.
  // Packed as {G, P, carry_out, sum}.
  function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0] full;
    logic [W:0] gen;
    gen  = {1'b0, x} + {1'b0, y};
    full = gen + {{W{1'b0}}, ci};
    return {gen[W], &(x ^ y), full};
  endfunction

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_random();
    a = rnd128();
    case ($urandom_range(0, 7))
      0:       b = ~a;
      1:       b = ~a ^ (128'd1 << $urandom_range(0, W-1));
      2:       b = '0;
      default: b = rnd128();
    endcase
    c = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a = '1;
    b = '1;
    c = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({G_ik, P_ik, carry_out, sum} !== '0) begin
      failures++;
      $display("FAIL reset_hold: got G=%b P=%b co=%b sum=%h, want all 0", G_ik, P_ik, carry_out, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    checks++;
    if (sum !== {W{1'b1}} || carry_out !== 1'b1 || G_ik !== 1'b1 || P_ik !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got G=%b P=%b co=%b sum=%h, want G=1 P=0 co=1 sum=all-ones",
               G_ik, P_ik, carry_out, sum);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    a = 128'd2045;
    b = 128'd3453456;
    c = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    checks++;
    if (sum !== 128'd3455502 || carry_out !== 1'b0 || P_ik !== 1'b0 || G_ik !== 1'b0) begin
      failures++;
      $display("FAIL basic: got G=%b P=%b co=%b sum=%0d, want G=0 P=0 co=0 sum=3455502",
               G_ik, P_ik, carry_out, sum);
    end
  endtask

  task automatic test_full_propagate();
    for (int ci = 1; ci >= 0; ci--) begin
      @(negedge clk);
      a = '1;
      b = '0;
      c = 1'(ci);
      repeat (LAT) @(posedge clk);
      #1;
      checks++;
      if (ci == 1 && (sum !== '0 || carry_out !== 1'b1 || P_ik !== 1'b1 || G_ik !== 1'b0)) begin
        failures++;
        $display("FAIL propagate_c1: got G=%b P=%b co=%b sum=%h, want G=0 P=1 co=1 sum=0",
                 G_ik, P_ik, carry_out, sum);
      end
      if (ci == 0 && (sum !== {W{1'b1}} || carry_out !== 1'b0 || P_ik !== 1'b1 || G_ik !== 1'b0)) begin
        failures++;
        $display("FAIL propagate_c0: got G=%b P=%b co=%b sum=%h, want G=0 P=1 co=0 sum=all-ones",
                 G_ik, P_ik, carry_out, sum);
      end
    end
  endtask

  task automatic test_full_generate();
    logic [W-1:0] exp_sum;
    exp_sum = {{(W-1){1'b1}}, 1'b0};
    @(negedge clk);
    a = '1;
    b = '1;
    c = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    checks++;
    if (sum !== exp_sum || carry_out !== 1'b1 || G_ik !== 1'b1 || P_ik !== 1'b0) begin
      failures++;
      $display("FAIL generate: got G=%b P=%b co=%b sum=%h, want G=1 P=0 co=1 sum=%h",
               G_ik, P_ik, carry_out, sum, exp_sum);
    end
  endtask

  task automatic test_back_to_back(input int n);
    logic [W+2:0] q[$];
    logic [W+2:0] e;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      drive_random();
      q.push_back(model(a, b, c));
      @(posedge clk);
      #1;
      checks++;
      if ((G_ik & P_ik) !== 1'b0) begin
        failures++;
        $display("FAIL invariant_gp: got G=%b P=%b, want G&P=0", G_ik, P_ik);
      end
      if (q.size() == LAT) begin
        e = q.pop_front();
        checks++;
        if ({G_ik, P_ik, carry_out, sum} !== e) begin
          failures++;
          $display("FAIL stream[%0d]: got G=%b P=%b co=%b sum=%h, want G=%b P=%b co=%b sum=%h",
                   t, G_ik, P_ik, carry_out, sum, e[W+2], e[W+1], e[W], e[W-1:0]);
        end
      end
    end
    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      e = q.pop_front();
      checks++;
      if ({G_ik, P_ik, carry_out, sum} !== e) begin
        failures++;
        $display("FAIL stream_drain: got G=%b P=%b co=%b sum=%h, want G=%b P=%b co=%b sum=%h",
                 G_ik, P_ik, carry_out, sum, e[W+2], e[W+1], e[W], e[W-1:0]);
      end
    end
  endtask

  task automatic test_async_reset_midstream();
    test_back_to_back(40);
    // Make sure the outputs are non-zero so a clear is observable.
    @(negedge clk);
    a = '1;
    b = '0;
    c = 1'b1;
    repeat (LAT) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({G_ik, P_ik, carry_out, sum} !== '0) begin
      failures++;
      $display("FAIL async_clear: got G=%b P=%b co=%b sum=%h, want all 0 before next edge",
               G_ik, P_ik, carry_out, sum);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({G_ik, P_ik, carry_out, sum} !== '0) begin
      failures++;
      $display("FAIL reset_held: got G=%b P=%b co=%b sum=%h, want all 0", G_ik, P_ik, carry_out, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_back_to_back(60);
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_full_propagate();
    test_full_generate();
    test_back_to_back(1000);
    test_async_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
